// File: rtl/hazard_ctrl_multi.sv
// Issue/fetch hazard controller for NUM_FU RS classes, MAX_BR unresolved branches and a timed post-mispredict flush.
// Optional stall-cycle counter is built only when HAZARD_PERF_CNT_EN is defined.
//
// state | meaning
// RUN   | normal issue; hazards gate IF/IS combinationally
// FLUSH | post-misprediction hold; IF/IS stalled and flushed until fcnt reaches 0
module hazard_ctrl_multi #(
  parameter int NUM_FU       = 3,
  parameter int MAX_BR       = 4,
  parameter int FLUSH_CYCLES = 2,
  parameter int PERF_W       = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              is_valid_inst,
  input  logic [NUM_FU-1:0] is_fu_sel,
  input  logic              is_branch,
  input  logic [NUM_FU-1:0] rs_full,
  input  logic              rob_full,
  input  logic              lb_full,
  input  logic              commit_wr_mem,
  input  logic              lb_read_mem,
  input  logic              acu_rd_mem,
  input  logic [NUM_FU-1:0] wr_valid,
  input  logic [NUM_FU-1:0] wr_written,
  input  logic              br_resolve,
  input  logic              branch_misprediction,
  output logic              if_enable,
  output logic              if_is_enable,
  output logic              if_is_flush,
  output logic              rob_enable,
  output logic [NUM_FU-1:0] rs_enable,
  output logic [NUM_FU-1:0] wr_enable,
  output logic [NUM_FU-1:0] exec_stall,
  output logic              ld_exec_stall,
  output logic              lb_exec_stall,
  output logic [3:0]        br_cnt,
  output logic [PERF_W-1:0] stall_cnt
);

  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [FW-1:0] F_LOAD = (FLUSH_CYCLES > 0) ? FW'(FLUSH_CYCLES - 1) : '0;
  localparam logic [3:0] BR_MAX = 4'(MAX_BR);

  typedef enum logic {RUN, FLUSH} state_t;

  state_t        state;
  logic [FW-1:0] fcnt;

  logic sel_onehot;
  logic rs_hit;
  logic in_flush;
  logic br_full;
  logic is_stall;
  logic is_enable;
  logic mem_haz;
  logic br_inc;

  assign wr_enable     = ~wr_valid | wr_written;
  assign exec_stall    = ~wr_enable;
  assign ld_exec_stall = (acu_rd_mem & lb_full) | exec_stall[0];
  assign lb_exec_stall = commit_wr_mem | exec_stall[0];

  // A zero or multi-hot class select never allocates an RS entry.
  assign sel_onehot = (is_fu_sel != '0) && ((is_fu_sel & (is_fu_sel - NUM_FU'(1))) == '0);
  assign rs_hit     = |(is_fu_sel & rs_full);
  assign in_flush   = (state == FLUSH);
  assign br_full    = is_branch & (br_cnt == BR_MAX);
  assign is_stall   = rob_full | rs_hit | br_full | in_flush;
  assign is_enable  = ~is_stall & is_valid_inst & ~branch_misprediction;

  assign rob_enable = is_enable;
  assign rs_enable  = sel_onehot ? (is_fu_sel & {NUM_FU{is_enable}}) : '0;

  assign mem_haz      = commit_wr_mem | lb_read_mem;
  assign if_enable    = ~(mem_haz | is_stall);
  assign if_is_enable = ~is_stall;
  assign if_is_flush  = branch_misprediction | in_flush | (mem_haz & ~is_stall);

  assign br_inc = is_branch & is_enable;

  // A misprediction squashes every younger branch, so it wins over inc/dec.
  always_ff @(posedge clock) begin
    if (reset) begin
      br_cnt <= 4'd0;
    end else if (branch_misprediction) begin
      br_cnt <= 4'd0;
    end else if (br_inc && !br_resolve) begin
      br_cnt <= br_cnt + 4'd1;
    end else if (br_resolve && !br_inc && (br_cnt != 4'd0)) begin
      br_cnt <= br_cnt - 4'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_misprediction && (FLUSH_CYCLES > 0)) begin
            state <= FLUSH;
            fcnt  <= F_LOAD;
          end
        end
        FLUSH: begin
          if (branch_misprediction) begin
            fcnt <= F_LOAD;
          end else if (fcnt == '0) begin
            state <= RUN;
          end else begin
            fcnt <= fcnt - 1'b1;
          end
        end
        default: begin
          state <= RUN;
          fcnt  <= '0;
        end
      endcase
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [PERF_W-1:0] stall_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stall_q <= '0;
    end else if (is_valid_inst && is_stall && (stall_q != '1)) begin
      stall_q <= stall_q + PERF_W'(1);
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl_multi.sv
// Scoreboard bench for hazard_ctrl_multi: directed vectors push hand-computed expectations,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_hazard_ctrl_multi;

  logic       clock = 1'b0;
  logic       reset;
  logic       is_valid_inst;
  logic [2:0] is_fu_sel;
  logic       is_branch;
  logic [2:0] rs_full;
  logic       rob_full;
  logic       lb_full;
  logic       commit_wr_mem;
  logic       lb_read_mem;
  logic       acu_rd_mem;
  logic [2:0] wr_valid;
  logic [2:0] wr_written;
  logic       br_resolve;
  logic       branch_misprediction;
  logic       if_enable;
  logic       if_is_enable;
  logic       if_is_flush;
  logic       rob_enable;
  logic [2:0] rs_enable;
  logic [2:0] wr_enable;
  logic [2:0] exec_stall;
  logic       ld_exec_stall;
  logic       lb_exec_stall;
  logic [3:0] br_cnt;
  logic [3:0] stall_cnt;

  hazard_ctrl_multi #(
    .NUM_FU(3), .MAX_BR(4), .FLUSH_CYCLES(2), .PERF_W(4)
  ) dut (
    .clock(clock), .reset(reset), .is_valid_inst(is_valid_inst), .is_fu_sel(is_fu_sel),
    .is_branch(is_branch), .rs_full(rs_full), .rob_full(rob_full), .lb_full(lb_full),
    .commit_wr_mem(commit_wr_mem), .lb_read_mem(lb_read_mem), .acu_rd_mem(acu_rd_mem),
    .wr_valid(wr_valid), .wr_written(wr_written), .br_resolve(br_resolve),
    .branch_misprediction(branch_misprediction), .if_enable(if_enable),
    .if_is_enable(if_is_enable), .if_is_flush(if_is_flush), .rob_enable(rob_enable),
    .rs_enable(rs_enable), .wr_enable(wr_enable), .exec_stall(exec_stall),
    .ld_exec_stall(ld_exec_stall), .lb_exec_stall(lb_exec_stall), .br_cnt(br_cnt),
    .stall_cnt(stall_cnt)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [18:0] vec;
    logic [3:0]  perf;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int checks   = 0;
  int failures = 0;
  logic [3:0]  exp_perf = 4'd0;
  logic [18:0] got;

  always @(negedge clock) begin
    if (sb.size() > 0) begin
      cur = sb.pop_front();
      got = {if_enable, if_is_enable, if_is_flush, rob_enable, rs_enable, wr_enable,
             exec_stall, ld_exec_stall, lb_exec_stall, br_cnt};
      checks++;
      if (got !== cur.vec || stall_cnt !== cur.perf) begin
        failures++;
        $display("FAIL %s: got out=%05h stall_cnt=%0d, expected out=%05h stall_cnt=%0d",
                 cur.name, got, stall_cnt, cur.vec, cur.perf);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
    reset = 0; is_valid_inst = 0; is_fu_sel = 3'b000; is_branch = 0; rs_full = 3'b000;
    rob_full = 0; lb_full = 0; commit_wr_mem = 0; lb_read_mem = 0; acu_rd_mem = 0;
    wr_valid = 3'b000; wr_written = 3'b000; br_resolve = 0; branch_misprediction = 0;
  endtask

  // Expected stall count advances by one per stalled valid cycle (IS stalled == ~if_is_enable).
  task automatic chk(input string n, input bit ife, input bit ifis, input bit fl, input bit rob,
                     input logic [2:0] rs, input logic [2:0] wr, input logic [2:0] ex,
                     input bit ld, input bit lb, input logic [3:0] br);
    exp_t e;
    e.name = n;
    e.vec  = {ife, ifis, fl, rob, rs, wr, ex, ld, lb, br};
`ifdef HAZARD_PERF_CNT_EN
    e.perf = exp_perf;
    if (reset) exp_perf = 4'd0;
    else if (is_valid_inst && !ifis && exp_perf != 4'hf) exp_perf = exp_perf + 4'd1;
`else
    e.perf = 4'd0;
`endif
    sb.push_back(e);
  endtask

  task automatic chk_main(input string n, input bit ife, input bit ifis, input bit fl,
                          input bit rob, input logic [2:0] rs, input logic [3:0] br);
    chk(n, ife, ifis, fl, rob, rs, 3'b111, 3'b000, 0, 0, br);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1);
  end

  initial begin
    reset = 1; is_valid_inst = 0; is_fu_sel = 3'b000; is_branch = 0; rs_full = 3'b000;
    rob_full = 0; lb_full = 0; commit_wr_mem = 0; lb_read_mem = 0; acu_rd_mem = 0;
    wr_valid = 3'b000; wr_written = 3'b000; br_resolve = 0; branch_misprediction = 0;
    repeat (3) @(posedge clock);

    cyc(); chk_main("reset_idle", 1, 1, 0, 0, 3'b000, 4'd0);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; rs_full = 3'b010;
    chk_main("rs_full_stall", 0, 0, 0, 0, 3'b000, 4'd0);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; rs_full = 3'b001;
    chk_main("rs_other_full_issue", 1, 1, 0, 1, 3'b010, 4'd0);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b001; rob_full = 1;
    chk_main("rob_full_stall", 0, 0, 0, 0, 3'b000, 4'd0);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b011;
    chk_main("multi_hot_sel", 1, 1, 0, 1, 3'b000, 4'd0);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b000;
    chk_main("zero_sel", 1, 1, 0, 1, 3'b000, 4'd0);

    for (int i = 0; i < 4; i++) begin
      cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; is_branch = 1;
      chk_main("branch_issue", 1, 1, 0, 1, 3'b010, 4'(i));
    end
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; is_branch = 1;
    chk_main("br_full_stall", 0, 0, 0, 0, 3'b000, 4'd4);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; is_branch = 1; br_resolve = 1;
    chk_main("br_full_resolve", 0, 0, 0, 0, 3'b000, 4'd4);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; is_branch = 1;
    chk_main("fifth_branch_issue", 1, 1, 0, 1, 3'b010, 4'd3);
    cyc(); chk_main("br_cnt_back_4", 1, 1, 0, 0, 3'b000, 4'd4);

    cyc(); br_resolve = 1; chk_main("resolve_4", 1, 1, 0, 0, 3'b000, 4'd4);
    cyc(); br_resolve = 1; chk_main("resolve_3", 1, 1, 0, 0, 3'b000, 4'd3);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; is_branch = 1; br_resolve = 1;
    chk_main("issue_and_resolve", 1, 1, 0, 1, 3'b010, 4'd2);
    cyc(); chk_main("br_cnt_held_2", 1, 1, 0, 0, 3'b000, 4'd2);
    cyc(); br_resolve = 1; chk_main("resolve_2", 1, 1, 0, 0, 3'b000, 4'd2);
    cyc(); br_resolve = 1; chk_main("resolve_1", 1, 1, 0, 0, 3'b000, 4'd1);
    cyc(); br_resolve = 1; chk_main("resolve_at_0", 1, 1, 0, 0, 3'b000, 4'd0);
    cyc(); chk_main("br_cnt_floor_0", 1, 1, 0, 0, 3'b000, 4'd0);

    for (int i = 0; i < 3; i++) begin
      cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; is_branch = 1;
      chk_main("branch_refill", 1, 1, 0, 1, 3'b010, 4'(i));
    end
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b010; branch_misprediction = 1;
    chk_main("mispredict_pulse", 1, 1, 1, 0, 3'b000, 4'd3);
    cyc(); is_valid_inst = 1; is_fu_sel = 3'b001;
    chk_main("flush_cycle_1", 0, 0, 1, 0, 3'b000, 4'd0);
    cyc(); chk_main("flush_cycle_2", 0, 0, 1, 0, 3'b000, 4'd0);
    cyc(); chk_main("back_to_run", 1, 1, 0, 0, 3'b000, 4'd0);

    cyc(); branch_misprediction = 1; chk_main("reload_pulse", 1, 1, 1, 0, 3'b000, 4'd0);
    cyc(); branch_misprediction = 1; chk_main("reload_in_flush", 0, 0, 1, 0, 3'b000, 4'd0);
    cyc(); chk_main("reload_flush_a", 0, 0, 1, 0, 3'b000, 4'd0);
    cyc(); chk_main("reload_flush_b", 0, 0, 1, 0, 3'b000, 4'd0);
    cyc(); chk_main("reload_run", 1, 1, 0, 0, 3'b000, 4'd0);

    cyc(); wr_valid = 3'b100;
    chk("wr_busy_fu2", 1, 1, 0, 0, 3'b000, 3'b011, 3'b100, 0, 0, 4'd0);
    cyc(); wr_valid = 3'b100; wr_written = 3'b100;
    chk("wr_consumed_fu2", 1, 1, 0, 0, 3'b000, 3'b111, 3'b000, 0, 0, 4'd0);
    cyc(); wr_valid = 3'b001;
    chk("wr_busy_fu0", 1, 1, 0, 0, 3'b000, 3'b110, 3'b001, 1, 1, 4'd0);
    cyc(); acu_rd_mem = 1; lb_full = 1;
    chk("load_lb_full", 1, 1, 0, 0, 3'b000, 3'b111, 3'b000, 1, 0, 4'd0);
    cyc(); commit_wr_mem = 1;
    chk("commit_mem_haz", 0, 1, 1, 0, 3'b000, 3'b111, 3'b000, 0, 1, 4'd0);
    cyc(); lb_read_mem = 1; rob_full = 1; is_valid_inst = 1; is_fu_sel = 3'b001;
    chk_main("mem_haz_under_stall", 0, 0, 0, 0, 3'b000, 4'd0);

    for (int i = 0; i < 20; i++) begin
      cyc(); is_valid_inst = 1; is_fu_sel = 3'b001; rob_full = 1;
      chk_main("perf_saturate", 0, 0, 0, 0, 3'b000, 4'd0);
    end

    cyc(); branch_misprediction = 1; chk_main("pre_reset_mispredict", 1, 1, 1, 0, 3'b000, 4'd0);
    cyc(); reset = 1; chk_main("reset_in_flush", 0, 0, 1, 0, 3'b000, 4'd0);
    cyc(); chk_main("run_after_reset", 1, 1, 0, 0, 3'b000, 4'd0);

    cyc();
    repeat (3) @(posedge clock);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_multi.md
Name: hazard_ctrl_multi

Overview:
- Parametrised issue/fetch hazard controller for the O3 pipeline.
- Generalises single-RS-class, single-branch hazard control to NUM_FU reservation-station/FU classes and up to MAX_BR outstanding unresolved branches.
- Adds a timed post-misprediction flush state machine.
- Sits between decode/IS, the reservation stations, the FU writeback registers, ROB, load buffer and commit.

Parameters:
- NUM_FU, 3: number of RS/FU classes. Index 0 is load/store, index 1 is ALU (branch-capable); others are general.
- MAX_BR, 4: maximum unresolved branches in flight; range 1..15.
- FLUSH_CYCLES, 2: extra cycles IF/IS stay flushed after a misprediction; 0 disables the FLUSH state.
- PERF_W, 32: width of the stall performance counter.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- is_valid_inst  in  1  IS stage holds a valid instruction
- is_fu_sel  in  NUM_FU  one-hot RS class of the IS instruction
- is_branch  in  1  IS instruction is a branch
- rs_full  in  NUM_FU  per-class RS full
- rob_full  in  1  ROB full
- lb_full  in  1  load buffer full
- commit_wr_mem  in  1  commit is writing memory this cycle
- lb_read_mem  in  1  load buffer is reading memory this cycle
- acu_rd_mem  in  1  ACU result is a load
- wr_valid  in  NUM_FU  per-FU writeback register valid
- wr_written  in  NUM_FU  per-FU writeback consumed this cycle
- br_resolve  in  1  one-cycle pulse, oldest in-flight branch resolved
- branch_misprediction  in  1  resolving branch mispredicted
- if_enable  out  1  advance IF
- if_is_enable  out  1  advance the IF/IS register
- if_is_flush  out  1  flush the IF/IS register
- rob_enable  out  1  allocate a ROB entry
- rs_enable  out  NUM_FU  per-class RS allocate
- wr_enable  out  NUM_FU  per-FU writeback register may load
- exec_stall  out  NUM_FU  per-FU exec stall
- ld_exec_stall  out  1  load/store RS exec stall
- lb_exec_stall  out  1  load buffer exec stall
- br_cnt  out  4  unresolved branches in flight
- stall_cnt  out  PERF_W  stall-cycle count

Behaviour:
- wr_enable[i] = ~wr_valid[i] | wr_written[i]; exec_stall[i] = ~wr_enable[i].
- ld_exec_stall = (acu_rd_mem & lb_full) | exec_stall[0].
- lb_exec_stall = commit_wr_mem | exec_stall[0].
- br_full = is_branch & (br_cnt == MAX_BR).
- is_stall = rob_full | OR(is_fu_sel & rs_full) | br_full | (state == FLUSH).
- is_enable = ~is_stall & is_valid_inst & ~branch_misprediction.
- rs_enable = is_fu_sel masked by is_enable; rob_enable = is_enable. is_fu_sel with zero or multiple bits set is illegal; no RS is enabled in that case.
- mem_haz = commit_wr_mem | lb_read_mem.
- if_enable = ~(mem_haz | is_stall); if_is_enable = ~is_stall.
- if_is_flush = branch_misprediction | (state == FLUSH) | (mem_haz & ~is_stall).
- br_cnt update, registered:
  - +1 on is_branch & is_enable.
  - −1 on br_resolve.
  - Both in the same cycle: unchanged.
  - Decrement at 0 is ignored; increment at MAX_BR cannot occur because br_full blocks it.
  - branch_misprediction clears br_cnt to 0 next cycle and overrides increment/decrement, since all younger branches are squashed.
- FSM states: RUN, FLUSH; flush counter fcnt.
  - RUN + branch_misprediction + FLUSH_CYCLES>0 → FLUSH, fcnt = FLUSH_CYCLES−1.
  - FLUSH: fcnt decrements each cycle; FLUSH → RUN when fcnt == 0.
  - branch_misprediction while in FLUSH reloads fcnt = FLUSH_CYCLES−1.
  - FLUSH_CYCLES == 0: FSM stays in RUN.
- Reset: state=RUN, fcnt=0, br_cnt=0, stall_cnt=0. Combinational outputs follow these reset state values. Reset asserted mid-FLUSH returns to RUN on the next edge.
- Latency: all enables and stalls are combinational from the current inputs and state; br_cnt and FSM changes take effect the following cycle.

Optional Feature:
- Macro HAZARD_PERF_CNT_EN.
- Defined: stall_cnt increments each cycle with is_valid_inst & is_stall, saturates at all ones, and clears on reset.
- Undefined: stall_cnt is constant 0 and no counter flops are built.

Test Plan:
- NUM_FU=3, is_fu_sel=3'b010, rs_full=3'b010, valid → rs_enable=0, if_enable=0, if_is_enable=0; same with rs_full=3'b001 → rs_enable=3'b010, rob_enable=1.
- 4 issued branches with no resolve (MAX_BR=4) → br_cnt=4. A 5th is_branch → is_stall=1 and rs_enable=0; br_resolve pulse → br_cnt=3, the 5th branch issues the next cycle, br_cnt returns to 4.
- Same-cycle branch issue and br_resolve with br_cnt=2 → br_cnt stays 2; br_resolve at br_cnt=0 → stays 0.
- branch_misprediction at br_cnt=3, FLUSH_CYCLES=2 → if_is_flush=1 for 3 consecutive cycles (pulse + 2 FLUSH), br_cnt=0, then RUN with if_is_enable=1.
- wr_valid=3'b100, wr_written=0 → wr_enable=3'b011, exec_stall=3'b100; wr_written=3'b100 → exec_stall=0. commit_wr_mem=1 with no stall → if_enable=0, if_is_flush=1, lb_exec_stall=1.
- HAZARD_PERF_CNT_EN, PERF_W=4: 20 stalled valid cycles → stall_cnt=15 (saturated); mid-run reset → stall_cnt=0 and state=RUN next cycle.
